// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the regfile write port between pipeline writeback (priority) and a buffered MUL/DIV result FIFO.
// Define RF_WR_FWD_EN to add src1/src2 pending-hazard flags against buffered FIFO entries.
module rf_wr_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          pipe_wr_en,
    input  logic [4:0]                    pipe_dest_addr,
    input  logic [31:0]                   pipe_wr_data,
    input  logic                          mc_valid,
    output logic                          mc_ready,
    input  logic [4:0]                    mc_dest_addr,
    input  logic [31:0]                   mc_wr_data,
    output logic                          stall_pipe,
    output logic [$clog2(FIFO_DEPTH):0]   mc_pending,
    output logic                          rf_wr_en,
    output logic [4:0]                    rf_dest_addr,
    output logic [31:0]                   rf_wr_data
`ifdef RF_WR_FWD_EN
    ,
    input  logic [4:0]                    src1_addr,
    input  logic [4:0]                    src2_addr,
    output logic                          src1_pend,
    output logic                          src2_pend
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [3:0] SL = 4'(STARVE_LIMIT);

    logic [4:0]    mem_addr_q [FIFO_DEPTH];
    logic [4:0]    mem_addr_d [FIFO_DEPTH];
    logic [31:0]   mem_data_q [FIFO_DEPTH];
    logic [31:0]   mem_data_d [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    starve_q, starve_d;
    logic          rf_wr_en_q, rf_wr_en_d;
    logic [4:0]    rf_dest_addr_q, rf_dest_addr_d;
    logic [31:0]   rf_wr_data_q, rf_wr_data_d;
    logic          empty, forced, grant_fifo, grant_pipe, enq;

    always_comb begin
        empty      = cnt_q == '0;
        mc_ready   = cnt_q != FULL;
        forced     = (starve_q == SL) && !empty;
        grant_fifo = forced || (!pipe_wr_en && !empty);
        grant_pipe = !forced && pipe_wr_en;
        enq        = mc_valid && mc_ready;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (enq) begin
            mem_addr_d[wr_ptr_q] = mc_dest_addr;
            mem_data_d[wr_ptr_q] = mc_wr_data;
        end
        wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = grant_fifo ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(enq) - CW'(grant_fifo);
        starve_d = (grant_fifo || empty) ? 4'd0 : (starve_q == SL) ? starve_q : starve_q + 4'd1;
        // x0 requests still consume their grant but never write the regfile
        rf_dest_addr_d = grant_pipe ? pipe_dest_addr : grant_fifo ? mem_addr_q[rd_ptr_q] : 5'd0;
        rf_wr_data_d   = grant_pipe ? pipe_wr_data : grant_fifo ? mem_data_q[rd_ptr_q] : 32'd0;
        rf_wr_en_d     = (grant_pipe || grant_fifo) && rf_dest_addr_d != 5'd0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            cnt_q          <= '0;
            starve_q       <= '0;
            rf_wr_en_q     <= 1'b0;
            rf_dest_addr_q <= '0;
            rf_wr_data_q   <= '0;
        end else begin
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            cnt_q          <= cnt_d;
            starve_q       <= starve_d;
            rf_wr_en_q     <= rf_wr_en_d;
            rf_dest_addr_q <= rf_dest_addr_d;
            rf_wr_data_q   <= rf_wr_data_d;
        end
    end

    assign stall_pipe   = forced;
    assign mc_pending   = cnt_q;
    assign rf_wr_en     = rf_wr_en_q;
    assign rf_dest_addr = rf_dest_addr_q;
    assign rf_wr_data   = rf_wr_data_q;

`ifdef RF_WR_FWD_EN
    // an entry is live when its distance from the read pointer is below occupancy
    always_comb begin
        src1_pend = 1'b0;
        src2_pend = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ({1'b0, AW'(i) - rd_ptr_q} < cnt_q) begin
                if (src1_addr != 5'd0 && mem_addr_q[i] == src1_addr) src1_pend = 1'b1;
                if (src2_addr != 5'd0 && mem_addr_q[i] == src2_addr) src2_pend = 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed vector table plus hand-written multi-cycle sequences for rf_wr_arbiter.
module tb_rf_wr_arbiter;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        pipe_wr_en = 1'b0;
    logic [4:0]  pipe_dest_addr = '0;
    logic [31:0] pipe_wr_data = '0;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_dest_addr = '0;
    logic [31:0] mc_wr_data = '0;
    logic        stall_pipe;
    logic [1:0]  mc_pending;
    logic        rf_wr_en;
    logic [4:0]  rf_dest_addr;
    logic [31:0] rf_wr_data;
`ifdef RF_WR_FWD_EN
    logic [4:0]  src1_addr = '0;
    logic [4:0]  src2_addr = '0;
    logic        src1_pend, src2_pend;
`endif
    int n_tests = 0;
    int n_fail = 0;

    rf_wr_arbiter dut (
        .clk(clk), .nrst(nrst),
        .pipe_wr_en(pipe_wr_en), .pipe_dest_addr(pipe_dest_addr), .pipe_wr_data(pipe_wr_data),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_dest_addr(mc_dest_addr), .mc_wr_data(mc_wr_data),
        .stall_pipe(stall_pipe), .mc_pending(mc_pending),
        .rf_wr_en(rf_wr_en), .rf_dest_addr(rf_dest_addr), .rf_wr_data(rf_wr_data)
`ifdef RF_WR_FWD_EN
        , .src1_addr(src1_addr), .src2_addr(src2_addr), .src1_pend(src1_pend), .src2_pend(src2_pend)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pe; logic [4:0] pa; logic [31:0] pd;
        logic mv; logic [4:0] ma; logic [31:0] md;
        logic en; logic [4:0] ea; logic [31:0] ed;
        logic [1:0] pend; logic rdy; logic stl;
    } vec_t;
    vec_t v [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        pipe_wr_en = pe; pipe_dest_addr = pa; pipe_wr_data = pd;
        mc_valid = mv; mc_dest_addr = ma; mc_wr_data = md;
    endtask

    task automatic chk_wr(input string name, input logic [4:0] a, input logic [31:0] d);
        chk({name, "_en"}, {31'd0, rf_wr_en}, 32'd1);
        chk({name, "_addr"}, {27'd0, rf_dest_addr}, {27'd0, a});
        chk({name, "_data"}, rf_wr_data, d);
    endtask

    initial begin
        v[0] = '{1, 5'd1,  32'hADE1B055, 0, 5'd0, 32'h0,        1, 5'd1,  32'hADE1B055, 2'd0, 1, 0};
        v[1] = '{0, 5'd0,  32'h0,        1, 5'd10, 32'h12345678, 0, 5'd0,  32'h0,        2'd1, 1, 0};
        v[2] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd10, 32'h12345678, 2'd0, 1, 0};
        v[3] = '{1, 5'd0,  32'h5,        0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        2'd0, 1, 0};
        v[4] = '{1, 5'd31, 32'hFFFFFFFF, 1, 5'd3, 32'h33,       1, 5'd31, 32'hFFFFFFFF, 2'd1, 1, 0};
        v[5] = '{1, 5'd2,  32'h22,       1, 5'd4, 32'h44,       1, 5'd2,  32'h22,       2'd2, 0, 0};
        v[6] = '{1, 5'd5,  32'h55,       1, 5'd6, 32'h66,       1, 5'd5,  32'h55,       2'd2, 0, 0};
        v[7] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd3,  32'h33,       2'd1, 1, 0};
        v[8] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd4,  32'h44,       2'd0, 1, 0};
        v[9] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        2'd0, 1, 0};

        tick(); tick();
        chk("rst_pending", {30'd0, mc_pending}, 32'd0);
        chk("rst_ready", {31'd0, mc_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        chk("rst_stall", {31'd0, stall_pipe}, 32'd0);
        chk("rst_addr", {27'd0, rf_dest_addr}, 32'd0);
        chk("rst_data", rf_wr_data, 32'd0);
        nrst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(v[i].pe, v[i].pa, v[i].pd, v[i].mv, v[i].ma, v[i].md);
            tick();
            chk($sformatf("vec%0d_en", i), {31'd0, rf_wr_en}, {31'd0, v[i].en});
            if (v[i].en) begin
                chk($sformatf("vec%0d_addr", i), {27'd0, rf_dest_addr}, {27'd0, v[i].ea});
                chk($sformatf("vec%0d_data", i), rf_wr_data, v[i].ed);
            end
            chk($sformatf("vec%0d_pending", i), {30'd0, mc_pending}, {30'd0, v[i].pend});
            chk($sformatf("vec%0d_ready", i), {31'd0, mc_ready}, {31'd0, v[i].rdy});
            chk($sformatf("vec%0d_stall", i), {31'd0, stall_pipe}, {31'd0, v[i].stl});
        end

        // starvation: one buffered entry against a continuously busy pipeline
        drive(1, 5'd8, 32'h88, 1, 5'd7, 32'h77);
        tick();
        mc_valid = 1'b0;
        chk("starve_pending", {30'd0, mc_pending}, 32'd1);
        chk("starve_stall0", {31'd0, stall_pipe}, 32'd0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("starve_stall_c%0d", c), {31'd0, stall_pipe}, 32'd0);
            chk_wr($sformatf("starve_pipe_c%0d", c), 5'd8, 32'h88);
        end
        tick();
        chk("starve_stall_c5", {31'd0, stall_pipe}, 32'd1);
        tick();
        chk_wr("starve_forced", 5'd7, 32'h77);
        chk("starve_stall_after", {31'd0, stall_pipe}, 32'd0);
        chk("starve_drained", {30'd0, mc_pending}, 32'd0);
        tick();
        chk_wr("starve_resume", 5'd8, 32'h88);

        // full: three back-to-back results while the pipeline is busy
        drive(1, 5'd9, 32'h99, 1, 5'd12, 32'hA);
        tick();
        chk("full_pend1", {30'd0, mc_pending}, 32'd1);
        chk("full_ready1", {31'd0, mc_ready}, 32'd1);
        mc_dest_addr = 5'd13; mc_wr_data = 32'hB;
        tick();
        chk("full_pend2", {30'd0, mc_pending}, 32'd2);
        chk("full_ready0", {31'd0, mc_ready}, 32'd0);
        mc_dest_addr = 5'd14; mc_wr_data = 32'hC;
        tick();
        chk("full_hold_pend", {30'd0, mc_pending}, 32'd2);
        chk("full_hold_ready", {31'd0, mc_ready}, 32'd0);
        pipe_wr_en = 1'b0;
        tick();
        chk_wr("full_drainA", 5'd12, 32'hA);
        chk("full_noenq_when_full", {30'd0, mc_pending}, 32'd1);
        tick();
        chk_wr("full_drainB", 5'd13, 32'hB);
        chk("full_enqC", {30'd0, mc_pending}, 32'd1);
        mc_valid = 1'b0;
        tick();
        chk_wr("full_drainC", 5'd14, 32'hC);
        chk("full_empty", {30'd0, mc_pending}, 32'd0);

`ifdef RF_WR_FWD_EN
        drive(0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD);
        tick();
        mc_valid = 1'b0;
        chk("x0_pend", {30'd0, mc_pending}, 32'd1);
        tick();
        chk("x0_no_write", {31'd0, rf_wr_en}, 32'd0);
        chk("x0_dequeued", {30'd0, mc_pending}, 32'd0);
        drive(1, 5'd1, 32'h1, 1, 5'd11, 32'hBB);
        src1_addr = 5'd11; src2_addr = 5'd12;
        tick();
        mc_valid = 1'b0;
        chk("fwd_src1_pend", {31'd0, src1_pend}, 32'd1);
        chk("fwd_src2_clear", {31'd0, src2_pend}, 32'd0);
        tick();
        chk("fwd_src1_hold", {31'd0, src1_pend}, 32'd1);
        pipe_wr_en = 1'b0;
        tick();
        chk_wr("fwd_drain", 5'd11, 32'hBB);
        chk("fwd_src1_done", {31'd0, src1_pend}, 32'd0);
`endif

        // async reset mid-fill discards buffered entries
        drive(1, 5'd20, 32'h20, 1, 5'd21, 32'h21);
        tick();
        mc_dest_addr = 5'd22;
        tick();
        chk("prerst_pending", {30'd0, mc_pending}, 32'd2);
        chk("prerst_wr_en", {31'd0, rf_wr_en}, 32'd1);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_pending", {30'd0, mc_pending}, 32'd0);
        chk("arst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        chk("arst_ready", {31'd0, mc_ready}, 32'd1);
        tick();
        nrst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("postrst_wr_en%0d", c), {31'd0, rf_wr_en}, 32'd0);
            chk($sformatf("postrst_pending%0d", c), {30'd0, mc_pending}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
